// File: rtl/led_pkg.sv
// Shared types and helpers for the LED fader: channel state encoding and the
// brightness-to-duty mapping (gamma curve when LED_FADE_GAMMA_EN is defined).
package led_pkg;

  localparam int         LED_N_DEF = 8;
  localparam logic [7:0] PWM_MAX   = 8'd255;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RISING  = 2'd1,
    ST_ON      = 2'd2,
    ST_FALLING = 2'd3
  } led_state_e;

  function automatic logic [7:0] duty_map(input logic [7:0] bright);
`ifdef LED_FADE_GAMMA_EN
    logic [15:0] sq;
    sq = {8'd0, bright} * {8'd0, bright};
    // Full brightness must stay fully on; 255*255>>8 would only give 254.
    return (bright == PWM_MAX) ? PWM_MAX : sq[15:8];
`else
    return bright;
`endif
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: steps brightness toward the target bit on each step tick and
// drives a registered PWM output (1 cycle from counter/duty to pin).
module led_fade_channel
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tgt_i,
  input  logic       step_tick_i,
  input  logic       enable_i,
  input  logic [7:0] pwm_cnt_i,
  output logic       led_o,
  output logic       busy_o
);

  led_state_e state;
  logic [7:0] bright_q, bright_d;
  logic       led_q, led_d;

  always_comb begin
    state = ST_OFF;
    if (tgt_i) begin
      state = (bright_q == PWM_MAX) ? ST_ON : ST_RISING;
    end else if (bright_q != 8'd0) begin
      state = ST_FALLING;
    end
  end

  always_comb begin
    bright_d = bright_q;
    led_d    = tgt_i;
    if (!enable_i) begin
      // Bypass keeps brightness parked at the rail so re-enabling is seamless.
      bright_d = tgt_i ? PWM_MAX : 8'd0;
    end else begin
      led_d = (pwm_cnt_i < duty_map(bright_q));
      if (step_tick_i) begin
        case (state)
          ST_RISING:  bright_d = bright_q + 8'd1;
          ST_FALLING: bright_d = bright_q - 8'd1;
          default:    bright_d = bright_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= 8'd0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      led_q    <= led_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = (state == ST_RISING) || (state == ST_FALLING);

endmodule

// File: rtl/led_fader.sv
// LED fader top: registers the target vector, runs the step prescaler and shared
// 255-cycle PWM counter, and ORs channel activity into busy. Gamma: LED_FADE_GAMMA_EN.
module led_fader
  import led_pkg::*;
#(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int FADE_STEP_DIV = CLK_FREQ / 1000,
  parameter int N_LEDS        = LED_N_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LEDS-1:0] leds_in,
  input  logic              enable,
  output logic [N_LEDS-1:0] leds_out,
  output logic              busy
);

  localparam int             PW         = (FADE_STEP_DIV > 1) ? $clog2(FADE_STEP_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(FADE_STEP_DIV - 1);

  logic [N_LEDS-1:0] tgt_q;
  logic [PW-1:0]     presc_q, presc_d;
  logic [7:0]        pwm_cnt_q, pwm_cnt_d;
  logic              busy_q, busy_d;
  logic              step_tick;
  logic [N_LEDS-1:0] ch_busy;

  always_comb begin
    step_tick = enable && (presc_q == PRESC_LAST);
    presc_d   = '0;
    if (enable && !step_tick) begin
      presc_d = presc_q + PW'(1);
    end
    pwm_cnt_d = (pwm_cnt_q == PWM_MAX - 8'd1) ? 8'd0 : pwm_cnt_q + 8'd1;
    busy_d    = enable && (|ch_busy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q     <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= 8'd0;
      busy_q    <= 1'b0;
    end else begin
      tgt_q     <= leds_in;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    led_fade_channel u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tgt_i      (tgt_q[i]),
      .step_tick_i(step_tick),
      .enable_i   (enable),
      .pwm_cnt_i  (pwm_cnt_q),
      .led_o      (leds_out[i]),
      .busy_o     (ch_busy[i])
    );
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: a fast-step instance (ramp, reversal, bypass,
// reset) and a PWM-aligned instance (per-period duty accuracy).
module tb_led_fader;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] leds_in_a, leds_in_b, leds_out_a, leds_out_b;
  logic       enable_a, enable_b, busy_a, busy_b;
  logic [7:0] bright0_a, bright7_a, pwm_b;

  always #5 clk = ~clk;

  led_fader #(.CLK_FREQ(4000), .FADE_STEP_DIV(4), .N_LEDS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .leds_in(leds_in_a), .enable(enable_a),
    .leds_out(leds_out_a), .busy(busy_a)
  );

  led_fader #(.CLK_FREQ(255000), .FADE_STEP_DIV(255), .N_LEDS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .leds_in(leds_in_b), .enable(enable_b),
    .leds_out(leds_out_b), .busy(busy_b)
  );

  assign bright0_a = dut_a.g_ch[0].u_ch.bright_q;
  assign bright7_a = dut_a.g_ch[7].u_ch.bright_q;
  assign pwm_b     = dut_b.pwm_cnt_q;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0h with no expectation", obs);
    end else begin
      x = sb_q.pop_front();
      checks++;
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", x.tag, obs, x.exp);
      end
    end
  endtask

  function automatic int duty_exp(input int k);
`ifdef LED_FADE_GAMMA_EN
    if (k >= 255) return 255;
    return (k * k) >> 8;
`else
    return (k > 255) ? 255 : k;
`endif
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n_inc, n_dec, bad, first, last, max_b, mism, h0, h7;
    logic [7:0] prev, cur;

    rst_n = 1'b0; leds_in_a = 8'h00; leds_in_b = 8'h00;
    enable_a = 1'b1; enable_b = 1'b1;
    cyc(3);
    push_exp("reset_leds_out", 0); check(leds_out_a);
    push_exp("reset_busy", 0);     check(busy_a);
    rst_n = 1'b1;
    cyc(5);

    // Full ramp of channel 0 with step divider 4.
    leds_in_a = 8'h01;
    prev = 8'd0; n_inc = 0; bad = 0; first = -1; last = -1;
    for (int c = 1; c <= 1200 && prev != 8'd255; c++) begin
      cyc(1);
      cur = bright0_a;
      if (c == 1) begin push_exp("busy_after_1", 0); check(busy_a); end
      if (c == 2) begin push_exp("busy_after_2", 1); check(busy_a); end
      if (cur != prev) begin
        if (cur != prev + 8'd1) bad++;
        if (n_inc == 0) first = c;
        last = c;
        n_inc++;
      end
      prev = cur;
    end
    push_exp("ramp_final_bright", 255);   check(bright0_a);
    push_exp("ramp_step_count", 255);     check(n_inc);
    push_exp("ramp_bad_steps", 0);        check(bad);
    push_exp("ramp_step_span", 254 * 4);  check(last - first);
    push_exp("ramp_first_step_window", 1); check((first >= 2 && first <= 5) ? 1 : 0);
    push_exp("busy_at_top", 1);           check(busy_a);
    cyc(1);
    push_exp("busy_after_top", 0);        check(busy_a);
    mism = 0;
    for (int c = 0; c < 300; c++) begin
      cyc(1);
      if (leds_out_a !== 8'h01) mism++;
    end
    push_exp("on_hold_leds_out", 0);      check(mism);

    // Park channel 0 at zero through bypass, then ramp to 100 and reverse.
    enable_a = 1'b0; leds_in_a = 8'h00;
    cyc(3);
    enable_a = 1'b1;
    push_exp("parked_bright", 0);         check(bright0_a);
    leds_in_a = 8'h01;
    for (int c = 0; c < 600 && bright0_a != 8'd100; c++) cyc(1);
    leds_in_a = 8'h00;
    push_exp("reversal_peak", 100);       check(bright0_a);
    prev = bright0_a; max_b = prev; n_dec = 0; bad = 0;
    for (int c = 0; c < 600 && prev != 8'd0; c++) begin
      cyc(1);
      cur = bright0_a;
      if (int'(cur) > max_b) max_b = cur;
      if (cur != prev) begin
        if (cur != prev - 8'd1) bad++;
        n_dec++;
      end
      prev = cur;
    end
    push_exp("reversal_max", 100);        check(max_b);
    push_exp("reversal_dec_count", 100);  check(n_dec);
    push_exp("reversal_bad_steps", 0);    check(bad);
    push_exp("busy_at_bottom", 1);        check(busy_a);
    cyc(1);
    push_exp("busy_after_bottom", 0);     check(busy_a);
    push_exp("off_leds_out", 0);          check(leds_out_a);

    // Bypass latency, then seamless re-enable.
    enable_a = 1'b0; leds_in_a = 8'hA5;
    cyc(1);
    push_exp("bypass_lat1", 8'h00);       check(leds_out_a);
    cyc(1);
    push_exp("bypass_lat2", 8'hA5);       check(leds_out_a);
    push_exp("bypass_busy", 0);           check(busy_a);
    enable_a = 1'b1;
    mism = 0;
    for (int c = 0; c < 1000; c++) begin
      cyc(1);
      if (leds_out_a !== 8'hA5 || busy_a !== 1'b0) mism++;
    end
    push_exp("reenable_glitch", 0);       check(mism);

    // Duty accuracy: steps aligned to PWM periods on instance b.
    for (int c = 0; c < 300 && pwm_b != 8'd100; c++) cyc(1);
    push_exp("align_pwm_mid", 100);       check(pwm_b);
    leds_in_b = 8'hFF;
    for (int c = 0; c < 300 && pwm_b != 8'd1; c++) cyc(1);
    push_exp("align_pwm_start", 1);       check(pwm_b);
    for (int k = 1; k <= 4; k++) begin
      push_exp($sformatf("duty_p%0d_bit0", k), duty_exp(k));
      push_exp($sformatf("duty_p%0d_bit7", k), duty_exp(k));
      h0 = 0; h7 = 0;
      for (int c = 0; c < 255; c++) begin
        h0 += int'(leds_out_b[0]);
        h7 += int'(leds_out_b[7]);
        cyc(1);
      end
      check(h0);
      check(h7);
    end

    // Asynchronous reset in the middle of a ramp.
    leds_in_a = 8'hFF;
    cyc(200);
    push_exp("pre_reset_busy", 1);        check(busy_a);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    push_exp("async_leds_out", 0);        check(leds_out_a);
    push_exp("async_busy", 0);            check(busy_a);
    push_exp("async_bright0", 0);         check(bright0_a);
    push_exp("async_bright7", 0);         check(bright7_a);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2);
    push_exp("post_release_bright", 0);   check(bright0_a);
    push_exp("post_release_leds", 0);     check(leds_out_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
